// File: rtl/cnt_pkg.sv
// Shared definitions for the up/down modulo counter family: count direction
// encoding, a clog2 that never returns 0, and the parameter range check used
// at elaboration by every counter instance.
package cnt_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

  // True when WIDTH, MODULUS and RESET_VAL describe a legal counter.
  function automatic bit cnt_params_ok(input int width, input int modulus, input int reset_val);
    return (width >= 1) && (modulus >= 2) && (clog2_safe(modulus) <= width) &&
           (reset_val >= 0) && (reset_val < modulus);
  endfunction

endpackage

// File: rtl/t_ff_stage.sv
// One counter bit built as a T flip-flop: the bit inverts on every rising
// edge where t is high. Asynchronous active-low reset loads RESET_BIT.
module t_ff_stage #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic t,
  output logic q
);

  logic q_r;

  // Toggle the stored bit when t is high; otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= RESET_BIT;
    end else if (t) begin
      q_r <= ~q_r;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous up/down modulo-MODULUS counter built from WIDTH T flip-flop
// stages. Priority per edge: clr > load > en. tc is combinational so that
// chained stages (tc -> next en) advance on the same edge; wrap is a
// registered one-cycle pulse after each wrapping edge.
// Build option: define SYNC_CNT_SATURATE_EN to make the counter stop at the
// end of its range instead of wrapping (wrap then never asserts).
module sync_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  if (!cnt_params_ok(WIDTH, MODULUS, RESET_VAL)) begin : g_bad_params
    $error("sync_updown_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  cnt_dir_e         dir_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] toggle_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] load_eff_s;
  logic             at_term_s;
  logic             tc_s;
  logic             wrap_next_s;
  logic             wrap_r;

  assign dir_s      = cnt_dir_e'(up_dn);
  assign at_term_s  = (dir_s == CNT_UP) ? (q_s == MAX_VAL) : (q_s == ZERO);
  assign tc_s       = en & at_term_s;
  // Out-of-range load values clamp to the top of the count range.
  assign load_eff_s = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Plain binary toggle pattern: a bit flips when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    logic up_all;
    logic dn_all;
    toggle_s = ZERO;
    up_all   = 1'b1;
    dn_all   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      toggle_s[i] = (dir_s == CNT_UP) ? up_all : dn_all;
      up_all      = up_all & q_s[i];
      dn_all      = dn_all & ~q_s[i];
    end
  end

  // Next-state mux expressed as toggle masks: clr/load/modulo boundary override the binary toggle.
  always_comb begin
    t_s         = ZERO;
    wrap_next_s = 1'b0;
    if (clr) begin
      t_s = q_s;
    end else if (load) begin
      t_s = q_s ^ load_eff_s;
    end else if (tc_s) begin
`ifdef SYNC_CNT_SATURATE_EN
      t_s = ZERO;
`else
      t_s         = q_s ^ ((dir_s == CNT_UP) ? ZERO : MAX_VAL);
      wrap_next_s = 1'b1;
`endif
    end else if (en) begin
      t_s = toggle_s;
    end else begin
      t_s = ZERO;
    end
  end

  // Register the wrap pulse so it appears in the cycle after the wrapping edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= wrap_next_s;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    t_ff_stage #(
      .RESET_BIT (RST_VEC[i])
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .t       (t_s[i]),
      .q       (q_s[i])
    );
  end

  assign q    = q_s;
  assign tc   = tc_s;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter: a 16-state counter, a 10-state
// counter with a non-zero reset value driven from a vector table, and a
// two-stage cascade forming an 8-bit count.
module tb_sync_updown_counter;

`ifdef SYNC_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       a_en, a_up, a_clr, a_load, a_tc, a_wrap;
  logic [3:0] a_lv, a_q;
  logic       b_en, b_up, b_clr, b_load, b_tc, b_wrap;
  logic [3:0] b_lv, b_q;
  logic       c_en, c0_tc, c0_wrap, c1_tc, c1_wrap;
  logic [3:0] c0_q, c1_q;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(a_en), .up_dn(a_up), .clr(a_clr),
    .load(a_load), .load_val(a_lv), .q(a_q), .tc(a_tc), .wrap(a_wrap));

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(5)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(b_en), .up_dn(b_up), .clr(b_clr),
    .load(b_load), .load_val(b_lv), .q(b_q), .tc(b_tc), .wrap(b_wrap));

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_c0 (
    .clk(clk), .reset_n(reset_n), .en(c_en), .up_dn(1'b1), .clr(1'b0),
    .load(1'b0), .load_val(4'd0), .q(c0_q), .tc(c0_tc), .wrap(c0_wrap));

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_c1 (
    .clk(clk), .reset_n(reset_n), .en(c0_tc), .up_dn(1'b1), .clr(1'b0),
    .load(1'b0), .load_val(4'd0), .q(c1_q), .tc(c1_tc), .wrap(c1_wrap));

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lv;
    logic       exp_tc;
    logic [3:0] exp_q;
    logic       exp_wrap;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // clr load en up lv | tc before edge, q after edge, wrap after edge  (MODULUS=10)
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd3,  1'b0, 4'd3, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd2, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd8, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  1'b0, 4'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd12, 1'b0, 4'd9, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 4'd0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd4,  1'b1, 4'd4, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd5, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd4, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 4'd9, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 4'd0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd1, 1'b0};

    reset_n = 1'b0;
    a_en = 1'b0; a_up = 1'b0; a_clr = 1'b0; a_load = 1'b0; a_lv = 4'd0;
    b_en = 1'b0; b_up = 1'b0; b_clr = 1'b0; b_load = 1'b0; b_lv = 4'd0;
    c_en = 1'b0;
    #12;
    check("rst_a_q",    32'(a_q),    32'd0);
    check("rst_a_wrap", 32'(a_wrap), 32'd0);
    check("rst_b_q",    32'(b_q),    32'd5);
    check("rst_b_wrap", 32'(b_wrap), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

`ifndef SYNC_CNT_SATURATE_EN
    // Full up count through the natural binary wrap.
    a_en = 1'b1; a_up = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      check("t1_tc", 32'(a_tc), 32'((k % 16) == 15));
      step();
      check("t1_q",    32'(a_q),    32'((k + 1) % 16));
      check("t1_wrap", 32'(a_wrap), 32'(k == 15));
    end
    a_en = 1'b0;

    // Vector table on the modulo-10 counter: down wrap, priority, clamp, unmasked tc.
    check("t2_start_q", 32'(b_q), 32'd5);
    for (int i = 0; i < 18; i++) begin
      b_clr = tbl[i].clr; b_load = tbl[i].load; b_en = tbl[i].en;
      b_up = tbl[i].up; b_lv = tbl[i].lv;
      #1;
      check($sformatf("tbl%0d_tc", i), 32'(b_tc), 32'(tbl[i].exp_tc));
      step();
      check($sformatf("tbl%0d_q", i),    32'(b_q),    32'(tbl[i].exp_q));
      check($sformatf("tbl%0d_wrap", i), 32'(b_wrap), 32'(tbl[i].exp_wrap));
    end
    b_clr = 1'b0; b_load = 1'b0; b_en = 1'b0;
`endif

    // Reset between clock edges wins immediately and holds across an edge.
    a_load = 1'b1; a_lv = 4'd15; a_en = 1'b0;
    b_load = 1'b1; b_lv = 4'd6;  b_en = 1'b0;
    step();
    check("t4_load_a", 32'(a_q), 32'd15);
    check("t4_load_b", 32'(b_q), 32'd6);
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    b_load = 1'b0;
    step();
    check("t4_a_q",    32'(a_q),    SAT ? 32'd15 : 32'd0);
    check("t4_a_wrap", 32'(a_wrap), SAT ? 32'd0 : 32'd1);
    check("t4_b_hold", 32'(b_q),    32'd6);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_async_b_q",  32'(b_q),    32'd5);
    check("t4_async_a_q",  32'(a_q),    32'd0);
    check("t4_async_wrap", 32'(a_wrap), 32'd0);
    step();
    check("t4_held_b_q", 32'(b_q), 32'd5);
    check("t4_held_a_q", 32'(a_q), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    a_en = 1'b0;
    b_en = 1'b1; b_up = 1'b1;
    step();
    check("t4_resume_b", 32'(b_q), 32'd6);
    check("t4_resume_a", 32'(a_q), 32'd0);
    b_en = 1'b0;

`ifndef SYNC_CNT_SATURATE_EN
    // Two 4-bit stages chained through tc form an 8-bit binary counter.
    c_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      logic [8:0] exp_v;
      step();
      exp_v = {(k == 255) ? 1'b1 : 1'b0, 8'((k + 1) % 256)};
      check("t5_cascade", 32'({c1_wrap, c1_q, c0_q}), 32'(exp_v));
    end
    check("t5_wrap0", 32'(c0_wrap), 32'd1);
    c_en = 1'b0;
`else
    // Saturating build: up count sticks at the top value with no wrap pulse.
    a_en = 1'b1; a_up = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      check("t6_tc", 32'(a_tc), 32'(k >= 15));
      step();
      check("t6_q",    32'(a_q),    (k >= 14) ? 32'd15 : 32'(k + 1));
      check("t6_wrap", 32'(a_wrap), 32'd0);
    end
    a_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
